// File: rtl/buzzer_booster_driver_mc.sv
// Multi-channel AXI4-Lite buzzer tone generator.
// Per-channel PWM tones with finite beeps, done flags and irq.
module buzzer_booster_driver_mc #(
  parameter int NUM_CH             = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int CNT_WIDTH          = 24
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [NUM_CH-1:0]             pwm_out,
  output logic                          irq
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int PW = AW - 4;
  localparam int CW = CNT_WIDTH;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic          awready_q, wready_q, bvalid_q;
  logic [1:0]    bresp_q, rresp_q;
  logic          arready_q, rvalid_q;
  logic [DW-1:0] rdata_q, rd_mux, wmask;

  logic [NUM_CH-1:0] en_q, en_n, done_q, done_n;
  logic [NUM_CH-1:0] ie_q, ie_n, pwm_q;
  logic [NUM_CH-1:0] wrap, auto_clr;

  logic [CW-1:0] per_sh_q  [NUM_CH];
  logic [CW-1:0] per_sh_n  [NUM_CH];
  logic [CW-1:0] duty_sh_q [NUM_CH];
  logic [CW-1:0] duty_sh_n [NUM_CH];
  logic [CW-1:0] per_act_q [NUM_CH];
  logic [CW-1:0] duty_act_q[NUM_CH];
  logic [CW-1:0] cnt_q     [NUM_CH];
  logic [15:0]   beep_q    [NUM_CH];
  logic [15:0]   beep_n    [NUM_CH];
  logic [15:0]   rem_q     [NUM_CH];

  logic [PW-1:0] aw_page, ar_page, aw_idx, ar_idx;
  logic [1:0]    aw_off, ar_off;
  logic          aw_glob, aw_chan, ar_glob, ar_chan;
  logic          wr_fire;
  logic          unused_addr;

  assign unused_addr = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_page = S_AXI_AWADDR[AW-1:4];
  assign aw_off  = S_AXI_AWADDR[3:2];
  assign aw_idx  = aw_page - PW'(1);
  assign aw_glob = (aw_page == '0) && (aw_off != 2'd3);
  assign aw_chan = (aw_page != '0)
                && (32'(aw_page) <= 32'(NUM_CH))
                && (aw_off != 2'd3);

  assign ar_page = S_AXI_ARADDR[AW-1:4];
  assign ar_off  = S_AXI_ARADDR[3:2];
  assign ar_idx  = ar_page - PW'(1);
  assign ar_glob = (ar_page == '0) && (ar_off != 2'd3);
  assign ar_chan = (ar_page != '0)
                && (32'(ar_page) <= 32'(NUM_CH))
                && (ar_off != 2'd3);

  // The write commits on the edge that completes the AW/W handshake.
  assign wr_fire = (w_state == W_IDLE) && awready_q;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old,
    input logic [DW-1:0] d,
    input logic [DW-1:0] m
  );
    return (old & ~m) | (d & m);
  endfunction

  // Expand byte strobes to a bit mask.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < DW / 8; b++)
      wmask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
  end

  // Wrap and beep-expiry detection per channel.
  always_comb begin
    wrap     = '0;
    auto_clr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wrap[c] = en_q[c]
             && (per_act_q[c] != '0)
             && (cnt_q[c] == per_act_q[c] - CW'(1));
      auto_clr[c] = wrap[c] && (rem_q[c] == 16'd1);
    end
  end

  // Next register-file state: hw auto-clear, then sw write on top.
  always_comb begin
    en_n   = en_q & ~auto_clr;
    done_n = done_q;
    ie_n   = ie_q;
    for (int c = 0; c < NUM_CH; c++) begin
      per_sh_n[c]  = per_sh_q[c];
      duty_sh_n[c] = duty_sh_q[c];
      beep_n[c]    = beep_q[c];
    end
    if (wr_fire && aw_glob) begin
      unique case (aw_off)
        2'd0: en_n = NUM_CH'(merge(DW'(en_q),
                                   S_AXI_WDATA, wmask));
        2'd1: done_n = done_q
                     & ~NUM_CH'(S_AXI_WDATA & wmask);
        2'd2: ie_n = NUM_CH'(merge(DW'(ie_q),
                                   S_AXI_WDATA, wmask));
        default: ;
      endcase
    end
    done_n = done_n | auto_clr;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_fire && aw_chan && aw_idx == PW'(c)) begin
        unique case (aw_off)
          2'd0: per_sh_n[c] = CW'(merge(DW'(per_sh_q[c]),
                                        S_AXI_WDATA, wmask));
          2'd1: duty_sh_n[c] = CW'(merge(DW'(duty_sh_q[c]),
                                         S_AXI_WDATA, wmask));
          2'd2: beep_n[c] = 16'(merge(DW'(beep_q[c]),
                                      S_AXI_WDATA, wmask));
          default: ;
        endcase
      end
    end
  end

  // Register read mux.
  always_comb begin
    rd_mux = '0;
    if (ar_glob) begin
      unique case (ar_off)
        2'd0: rd_mux = DW'(en_q);
        2'd1: rd_mux = DW'(done_q) | (DW'(en_q) << 8);
        2'd2: rd_mux = DW'(ie_q);
        default: ;
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (ar_chan && ar_idx == PW'(c)) begin
        unique case (ar_off)
          2'd0: rd_mux = DW'(per_sh_q[c]);
          2'd1: rd_mux = DW'(duty_sh_q[c]);
          2'd2: rd_mux = DW'(beep_q[c]);
          default: ;
        endcase
      end
    end
  end

  // AXI write and read channel FSMs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= (aw_glob || aw_chan) ? 2'b00 : 2'b10;
            w_state   <= W_RESP;
          end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
      unique case (r_state)
        R_IDLE: begin
          if (arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_mux;
            rresp_q   <= (ar_glob || ar_chan) ? 2'b00 : 2'b10;
            r_state   <= R_DATA;
          end else if (S_AXI_ARVALID) begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Register file and per-channel tone generators.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      en_q   <= '0;
      done_q <= '0;
      ie_q   <= '0;
      pwm_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        per_sh_q[c]   <= '0;
        duty_sh_q[c]  <= '0;
        per_act_q[c]  <= '0;
        duty_act_q[c] <= '0;
        cnt_q[c]      <= '0;
        beep_q[c]     <= '0;
        rem_q[c]      <= '0;
      end
    end else begin
      en_q   <= en_n;
      done_q <= done_n;
      ie_q   <= ie_n;
      for (int c = 0; c < NUM_CH; c++) begin
        per_sh_q[c]  <= per_sh_n[c];
        duty_sh_q[c] <= duty_sh_n[c];
        beep_q[c]    <= beep_n[c];
        if (en_n[c] && !en_q[c])
          rem_q[c] <= beep_q[c];
        else if (wrap[c] && rem_q[c] != 16'd0)
          rem_q[c] <= rem_q[c] - 16'd1;
        if (!en_q[c] || !en_n[c]) begin
          cnt_q[c]      <= '0;
          pwm_q[c]      <= 1'b0;
          per_act_q[c]  <= per_sh_n[c];
          duty_act_q[c] <= duty_sh_n[c];
        end else begin
          pwm_q[c] <= (per_act_q[c] != '0)
                   && (cnt_q[c] < duty_act_q[c]);
          if (per_act_q[c] == '0) begin
            cnt_q[c] <= '0;
          end else if (wrap[c]) begin
            cnt_q[c]      <= '0;
            per_act_q[c]  <= per_sh_n[c];
            duty_act_q[c] <= duty_sh_n[c];
          end else begin
            cnt_q[c] <= cnt_q[c] + CW'(1);
          end
        end
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign pwm_out       = pwm_q;
  assign irq           = |(done_q & ie_q);

endmodule
